// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and handshake FSM states.
// The optional divider is controlled by the ALU_MC_DIV_EN macro in the users of this package.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift engine shared by the multiplier and the optional restoring divider.
// One bit per cycle, WIDTH iterations after start. Divider compiled in with ALU_MC_DIV_EN.
// Register roles: hi = accumulator / partial remainder, lo = multiplier / dividend->quotient,
// opnd = multiplicand (shifted left) / divisor (fixed).
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             done_c,
`ifdef ALU_MC_DIV_EN
  output logic [WIDTH-1:0] quotient_c,
  output logic [WIDTH-1:0] remainder_c,
`endif
  output logic [WIDTH-1:0] product_c
);

  logic             running;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] hi_nx, lo_nx, opnd_nx;

`ifdef ALU_MC_DIV_EN
  logic         mode_q;
  logic [WIDTH:0] r_sh;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  // Last iteration is the one performed at the edge where done_c is high.
  assign done_c    = running && (count == CNT_W'(WIDTH - 1));
  assign product_c = hi_nx;
`ifdef ALU_MC_DIV_EN
  assign quotient_c  = lo_nx;
  assign remainder_c = hi_nx;
`endif

  // One iteration step of the selected operation.
  always_comb begin
    hi_nx   = hi;
    lo_nx   = lo;
    opnd_nx = opnd;
`ifdef ALU_MC_DIV_EN
    r_sh    = {hi, lo[WIDTH-1]};
    if (mode_q) begin
      if (r_sh >= {1'b0, opnd}) begin
        hi_nx = WIDTH'(r_sh - {1'b0, opnd});
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = r_sh[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end else
`endif
    begin
      if (lo[0]) hi_nx = hi + opnd;
      opnd_nx = opnd << 1;
      lo_nx   = lo >> 1;
    end
  end

  // Engine registers: load on start, iterate while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
`ifdef ALU_MC_DIV_EN
      mode_q  <= 1'b0;
`endif
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      hi      <= '0;
`ifdef ALU_MC_DIV_EN
      mode_q  <= mode;
      lo      <= mode ? operand_a : operand_b;
      opnd    <= mode ? operand_b : operand_a;
`else
      lo      <= operand_b;
      opnd    <= operand_a;
`endif
    end else if (running) begin
      hi    <= hi_nx;
      lo    <= lo_nx;
      opnd  <= opnd_nx;
      count <= count + CNT_W'(1);
      if (done_c) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on operands and result.
// Simple ops complete in one cycle; MUL (and DIVU/REMU when ALU_MC_DIV_EN is defined)
// take WIDTH+1 cycles through the shared iterative engine.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    operand_a,
  input  logic [WIDTH-1:0]    operand_b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                busy
);

  alu_state_e       state, state_next;
  alu_op_e          op_c;
  logic [WIDTH-1:0] simple_c;
  logic [WIDTH-1:0] load_val_c;
  logic             load_c;
  logic             start_c;
  logic             mode_c;
  logic             done_c;
  logic [WIDTH-1:0] product_c;
`ifdef ALU_MC_DIV_EN
  logic [WIDTH-1:0] quotient_c;
  logic [WIDTH-1:0] remainder_c;
  logic             is_rem_q;
`endif

  assign op_c = alu_op_e'(alu_control);

  alu_muldiv_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk        (clk),
    .reset      (reset),
    .start      (start_c),
    .mode       (mode_c),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .done_c     (done_c),
`ifdef ALU_MC_DIV_EN
    .quotient_c (quotient_c),
    .remainder_c(remainder_c),
`endif
    .product_c  (product_c)
  );

  // Single-cycle operations; unknown codes (and DIVU/REMU without the divider) give 0.
  always_comb begin
    simple_c = '0;
    case (op_c)
      OP_AND:  simple_c = operand_a & operand_b;
      OP_OR:   simple_c = operand_a | operand_b;
      OP_ADD:  simple_c = operand_a + operand_b;
      OP_XOR:  simple_c = operand_a ^ operand_b;
      OP_SUB:  simple_c = operand_a - operand_b;
      OP_SLT:  simple_c = WIDTH'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: simple_c = WIDTH'(operand_a < operand_b);
      default: simple_c = '0;
    endcase
  end

  // Next-state and result-load decode for the handshake FSM.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    load_val_c = '0;
    start_c    = 1'b0;
    mode_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          case (op_c)
            OP_MUL: begin
              start_c    = 1'b1;
              state_next = ST_MUL;
            end
`ifdef ALU_MC_DIV_EN
            OP_DIVU, OP_REMU: begin
              start_c    = 1'b1;
              mode_c     = 1'b1;
              state_next = ST_DIV;
            end
`endif
            default: begin
              load_c     = 1'b1;
              load_val_c = simple_c;
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (done_c) begin
          load_c     = 1'b1;
          load_val_c = product_c;
          state_next = ST_DONE;
        end
      end
`ifdef ALU_MC_DIV_EN
      ST_DIV: begin
        if (done_c) begin
          load_c     = 1'b1;
          load_val_c = is_rem_q ? remainder_c : quotient_c;
          state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Registered handshake flags, result and zero flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_rem_q  <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_next == ST_IDLE);
      out_valid <= (state_next == ST_DONE);
      busy      <= (state_next != ST_IDLE);
      if (load_c) begin
        result <= load_val_c;
        zero   <= (load_val_c == '0);
      end
`ifdef ALU_MC_DIV_EN
      if (start_c) is_rem_q <= (op_c == OP_REMU);
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32), directed scenarios plus randomized ops
// against an arithmetic reference model. Divider expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int errors = 0;
  int checks = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model straight from the operation table.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd6:  r = a - b;
      4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  r = (a < b) ? 1 : 0;
      4'd9:  r = a * b;
`ifdef ALU_MC_DIV_EN
      4'd10: r = (b == 0) ? {W{1'b1}} : a / b;
      4'd11: r = (b == 0) ? a : a % b;
`endif
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    if (op == 4'd9 || op == 4'd10 || op == 4'd11) return W + 1;
`else
    if (op == 4'd9) return W + 1;
`endif
    return 1;
  endfunction

  // Drive one operation, wait for the result, then handshake it. Inputs are scrambled
  // (including in_valid pulses) while the result is pending.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat,
                        output logic ready_leak, output logic timed_out);
    int n;
    timed_out  = 1'b0;
    ready_leak = 1'b0;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timed_out = 1'b1;
    in_valid    = 1'b1;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    out_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 200) begin
      in_valid    = 1'($urandom_range(0, 1));
      alu_control = 4'($urandom);
      operand_a   = $urandom;
      operand_b   = $urandom;
      if (in_ready) ready_leak = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) timed_out = 1'b1;
    in_valid  = 1'b0;
    res       = result;
    z         = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    in_valid    = 1'b1;
    alu_control = 4'd2;
    operand_a   = 32'd5;
    operand_b   = 32'd6;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, zero, busy} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b zero=%b busy=%b result=%h, required all 0",
               in_ready, out_valid, zero, busy, result);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_wrap();
    logic [W-1:0] r; logic z, leak, to; int lat;
    run_op(4'd2, 32'hFFFF_FFFF, 32'd1, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'd0 || z !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL add_wrap: result=%h zero=%b lat=%0d to=%b, required 0 1 1 0", r, z, lat, to);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_compare();
    logic [W-1:0] r; logic z, leak, to; int lat;
    run_op(4'd7, 32'hFFFF_FFFF, 32'd1, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'd1 || z !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL slt: result=%h zero=%b lat=%0d, required 1 0 1", r, z, lat);
    end
    run_op(4'd8, 32'hFFFF_FFFF, 32'd1, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'd0 || z !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL sltu: result=%h zero=%b lat=%0d, required 0 1 1", r, z, lat);
    end
    run_op(4'd5, 32'h1234_5678, 32'h0F0F_0F0F, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'd0 || z !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL illegal_0101: result=%h zero=%b lat=%0d, required 0 1 1", r, z, lat);
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; logic z, leak, to; int lat;
    run_op(4'd9, 32'h0001_0003, 32'h0000_0005, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'h0005_000F || z !== 1'b0 || lat != 33) begin
      errors++;
      $display("FAIL mul: result=%h zero=%b lat=%0d, required 0005000f 0 33", r, z, lat);
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL mul_in_ready: in_ready seen high while busy=%b, required 0", leak);
    end
  endtask

  task automatic test_div();
    logic [W-1:0] r; logic z, leak, to; int lat;
    logic [3:0]   ops [4] = '{4'd10, 4'd11, 4'd10, 4'd11};
    logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_MC_DIV_EN
    logic [W-1:0] exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
    int           elat = 33;
`else
    logic [W-1:0] exp [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    int           elat = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], r, z, lat, leak, to);
      checks++;
      if (to || r !== exp[i] || z !== (exp[i] == 0) || lat != elat) begin
        errors++;
        $display("FAIL div_%0d: result=%h zero=%b lat=%0d, required %h %b %0d",
                 i, r, z, lat, exp[i], exp[i] == 0, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid    = 1'b1;
    alu_control = 4'd2;
    operand_a   = 32'd3;
    operand_b   = 32'd4;
    out_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    operand_a = 32'd99;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd7 || zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b result=%h in_ready=%b, required 1 7 0",
                 i, out_valid, result, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r; logic z, leak, to; int lat;
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid    = 1'b1;
    alu_control = 4'd9;
    operand_a   = 32'h0000_1234;
    operand_b   = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_mul_busy: busy=%b, required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || busy !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL mid_mul_reset: out_valid=%b result=%h busy=%b zero=%b, required 0 0 0 0",
               out_valid, result, busy, zero);
    end
    run_op(4'd2, 32'd1, 32'd1, r, z, lat, leak, to);
    checks++;
    if (to || r !== 32'd2 || z !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL post_reset_add: result=%h zero=%b lat=%0d, required 2 0 1", r, z, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r, a, b, e; logic z, leak, to; int lat;
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      if (i % 7 == 0) b = a;
      e  = ref_alu(op, a, b);
      run_op(op, a, b, r, z, lat, leak, to);
      checks++;
      if (to || leak || r !== e || z !== (e == 0) || lat != ref_lat(op)) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h: result=%h zero=%b lat=%0d, required %h %b %0d",
                 i, op, a, b, r, z, lat, e, e == 0, ref_lat(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_compare();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
